// File: rtl/plru_repl_engine_pkg.sv
// Shared types and defaults for the tree-PLRU replacement engine.
package plru_repl_engine_pkg;

    localparam int DEF_N_WAY  = 16;
    localparam int DEF_N_SETS = 64;

    typedef enum logic [1:0] {
        TOUCH     = 2'd0,
        VICTIM    = 2'd1,
        CLEAR_SET = 2'd2,
        RSVD      = 2'd3
    } plru_op_e;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_CALC,
        ST_RESP
    } plru_state_e;

    function automatic int PlruTreeWidth(input int n_way);
        return n_way - 1;
    endfunction

endpackage

// File: rtl/plru_repl_engine_if.sv
// Request/response bundle between the cache controller and the PLRU engine.
interface plru_repl_engine_if
    import plru_repl_engine_pkg::*;
#(
    parameter int N_WAY  = DEF_N_WAY,
    parameter int N_SETS = DEF_N_SETS
);
    logic                      req_valid;
    logic                      req_ready;
    plru_op_e                  req_op;
    logic [$clog2(N_SETS)-1:0] req_set;
    logic [$clog2(N_WAY)-1:0]  req_way;
    logic [N_WAY-1:0]          req_inv_mask;
    logic                      resp_valid;
    logic [$clog2(N_WAY)-1:0]  resp_way;
    logic                      resp_from_inv;
    logic                      init_done;

    modport master (
        output req_valid, req_op, req_set, req_way, req_inv_mask,
        input  req_ready, resp_valid, resp_way, resp_from_inv, init_done
    );

    modport slave (
        input  req_valid, req_op, req_set, req_way, req_inv_mask,
        output req_ready, resp_valid, resp_way, resp_from_inv, init_done
    );
endinterface

// File: rtl/plru_repl_engine_tree_logic.sv
// Combinational victim selection and path update over one set's PLRU tree bits.
module plru_tree_logic
    import plru_repl_engine_pkg::*;
#(
    parameter int  N_WAY           = DEF_N_WAY,
    parameter bit  TOUCH_ON_VICTIM = 1'b1,
    localparam int TW              = PlruTreeWidth(N_WAY),
    localparam int WAY_W           = $clog2(N_WAY)
) (
    input  logic [TW-1:0]    bits,
    input  plru_op_e         op,
    input  logic [WAY_W-1:0] way,
    input  logic [N_WAY-1:0] inv_mask,
    output logic [WAY_W-1:0] victim,
    output logic             from_inv,
    output logic [TW-1:0]    next_bits
);
    typedef logic [WAY_W-1:0] idx_t;

    idx_t tree_victim;
    idx_t inv_victim;
    idx_t target;

    // Walk away from the most recent half at each level; victim bits come out MSB first.
    always_comb begin : walk_tree
        idx_t n;
        logic d;
        n           = '0;
        d           = 1'b0;
        tree_victim = '0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            d                            = ~bits[n];
            tree_victim[WAY_W-1-lvl]     = d;
            n                            = (n << 1) + idx_t'(1) + idx_t'(d);
        end
    end

    always_comb begin : pick_invalid
        inv_victim = '0;
        for (int i = N_WAY - 1; i >= 0; i--) begin
            if (inv_mask[i]) inv_victim = idx_t'(i);
        end
    end

    assign from_inv = |inv_mask;
    assign victim   = from_inv ? inv_victim : tree_victim;
    assign target   = (op == VICTIM) ? victim : way;

    // Point every node on the target's path toward the target, leaving other nodes alone.
    always_comb begin : update_tree
        idx_t n;
        logic d;
        n         = '0;
        d         = 1'b0;
        next_bits = bits;
        if (op == CLEAR_SET) begin
            next_bits = '0;
        end else if (op == TOUCH || (op == VICTIM && TOUCH_ON_VICTIM)) begin
            for (int lvl = 0; lvl < WAY_W; lvl++) begin
                d            = target[WAY_W-1-lvl];
                next_bits[n] = d;
                n            = (n << 1) + idx_t'(1) + idx_t'(d);
            end
        end
    end

endmodule

// File: rtl/plru_repl_engine.sv
// Tree-PLRU replacement engine: per-set tree storage, init sweep and a
// single-outstanding-request FSM (accept -> calc -> resp).
module plru_repl_engine
    import plru_repl_engine_pkg::*;
#(
    parameter int N_WAY           = DEF_N_WAY,
    parameter int N_SETS          = DEF_N_SETS,
    parameter bit TOUCH_ON_VICTIM = 1'b1
) (
    input logic               clk,
    input logic               rst,
    plru_repl_engine_if.slave bus
);
    localparam int TW    = PlruTreeWidth(N_WAY);
    localparam int WAY_W = $clog2(N_WAY);
    localparam int SET_W = $clog2(N_SETS);

    if (N_WAY < 2 || N_WAY > 64 || (N_WAY & (N_WAY - 1)) != 0) begin : g_bad_n_way
        $fatal(1, "plru_repl_engine: N_WAY must be a power of 2 in 2..64");
    end
    if (N_SETS < 2 || (N_SETS & (N_SETS - 1)) != 0) begin : g_bad_n_sets
        $fatal(1, "plru_repl_engine: N_SETS must be a power of 2, at least 2");
    end

    plru_state_e      state, state_next;
    logic [TW-1:0]    tree_mem [N_SETS];
    logic [SET_W-1:0] init_cnt;
    logic [SET_W-1:0] set_q;
    plru_op_e         op_q;
    logic [WAY_W-1:0] way_q;
    logic [N_WAY-1:0] mask_q;
    logic [TW-1:0]    next_bits_q;
    logic [WAY_W-1:0] resp_way_q;
    logic             resp_from_inv_q;
    logic             init_done_q;
    logic             ready_c;
    logic             resp_c;
    logic             accept;
    logic [WAY_W-1:0] tl_victim;
    logic             tl_from_inv;
    logic [TW-1:0]    tl_next;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_INIT;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        ready_c    = 1'b0;
        resp_c     = 1'b0;
        case (state)
            ST_INIT: if (init_cnt == SET_W'(N_SETS - 1)) state_next = ST_IDLE;
            ST_IDLE: begin
                ready_c = 1'b1;
                if (bus.req_valid) state_next = ST_CALC;
            end
            ST_CALC: state_next = ST_RESP;
            ST_RESP: begin
                resp_c     = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_INIT;
        endcase
    end

    assign accept = ready_c & bus.req_valid;

    plru_tree_logic #(
        .N_WAY           (N_WAY),
        .TOUCH_ON_VICTIM (TOUCH_ON_VICTIM)
    ) u_tree (
        .bits      (tree_mem[set_q]),
        .op        (op_q),
        .way       (way_q),
        .inv_mask  (mask_q),
        .victim    (tl_victim),
        .from_inv  (tl_from_inv),
        .next_bits (tl_next)
    );

    // Response fields are registered at the end of CALC so they hold after the pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            init_cnt        <= '0;
            init_done_q     <= 1'b0;
            set_q           <= '0;
            op_q            <= TOUCH;
            way_q           <= '0;
            mask_q          <= '0;
            next_bits_q     <= '0;
            resp_way_q      <= '0;
            resp_from_inv_q <= 1'b0;
        end else begin
            if (state == ST_INIT) init_cnt <= init_cnt + SET_W'(1);
            if (state == ST_INIT && state_next == ST_IDLE) init_done_q <= 1'b1;
            if (accept) begin
                op_q   <= bus.req_op;
                set_q  <= bus.req_set;
                way_q  <= bus.req_way;
                mask_q <= bus.req_inv_mask;
            end
            if (state == ST_CALC) begin
                next_bits_q     <= tl_next;
                resp_from_inv_q <= (op_q == VICTIM) && tl_from_inv;
                case (op_q)
                    VICTIM:  resp_way_q <= tl_victim;
                    TOUCH:   resp_way_q <= way_q;
                    default: resp_way_q <= '0;
                endcase
            end
        end
    end

    // A reset landing in RESP must not commit the aborted request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_INIT)      tree_mem[init_cnt] <= '0;
            else if (state == ST_RESP) tree_mem[set_q]    <= next_bits_q;
        end
    end

    assign bus.req_ready     = ready_c & ~rst;
    assign bus.resp_valid    = resp_c & ~rst;
    assign bus.resp_way      = resp_way_q;
    assign bus.resp_from_inv = resp_from_inv_q;
    assign bus.init_done     = init_done_q;

    a_no_early_accept: assert property (@(posedge clk) disable iff (rst)
        (bus.req_valid && bus.req_ready) |-> bus.init_done);
    a_resp_single_pulse: assert property (@(posedge clk) disable iff (rst)
        bus.resp_valid |=> !bus.resp_valid);

endmodule
